// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU feeding the #5 pipe registers. Defining EXE_MDU_EN adds a
// single-cycle multiplier and a 32-iteration restoring divider that stalls the issue stage.
module exe_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid4,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [3:0]      alu_fn4,
  input  logic            m_en4,
  input  logic [2:0]      m_op4,
  input  logic [4:0]      rd4,
  input  logic            we4,
  output logic            stall,
  output logic            valid5,
  output logic [XLEN-1:0] result5,
  output logic [4:0]      rd5,
  output logic            we5
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;

  logic            valid5_q, valid5_d;
  logic [XLEN-1:0] result5_q, result5_d;
  logic [4:0]      rd5_q, rd5_d;
  logic            we5_q, we5_d;

  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_fn4)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a << shamt;
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'd5:    alu_res = op_a ^ op_b;
      4'd6:    alu_res = op_a >> shamt;
      4'd7:    alu_res = $unsigned($signed(op_a) >>> shamt);
      4'd8:    alu_res = op_a | op_b;
      4'd9:    alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
  end

`ifdef EXE_MDU_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            is_rem_q, is_rem_d;
  logic [4:0]      rd_div_q, rd_div_d;
  logic            we_div_q, we_div_d;
  logic            post_rst_q, post_rst_d;

  logic                   mul_a_sx, mul_b_sx;
  logic signed [2*XLEN-1:0] mul_a, mul_b, mul_p;
  logic [XLEN-1:0]        mul_res;

  logic            is_div, div_sgn, div_zero, div_ovf, div_special, div_start;
  logic [XLEN-1:0] div_special_res, a_mag, b_mag;
  logic [XLEN:0]   rem_sh, rem_sub;
  logic [XLEN-1:0] quo_fix, rem_fix, div_fin_res, exe_res;

  // Operands are sign/zero extended to 64 bits so one signed multiply covers all four ops.
  assign mul_a_sx = op_a[XLEN-1] & (m_op4[1:0] != 2'd3);
  assign mul_b_sx = op_b[XLEN-1] & (m_op4[1:0] == 2'd1);
  assign mul_a    = {{XLEN{mul_a_sx}}, op_a};
  assign mul_b    = {{XLEN{mul_b_sx}}, op_b};
  assign mul_p    = mul_a * mul_b;
  assign mul_res  = (m_op4[1:0] == 2'd0) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];

  assign is_div      = m_en4 & m_op4[2];
  assign div_sgn     = ~m_op4[0];
  assign div_zero    = (op_b == '0);
  assign div_ovf     = div_sgn & (op_a == MIN_NEG) & (op_b == '1);
  assign div_special = div_zero | div_ovf;
  assign div_special_res = div_zero ? (m_op4[1] ? op_a : '1)
                                    : (m_op4[1] ? '0   : MIN_NEG);
  assign a_mag = (div_sgn & op_a[XLEN-1]) ? -op_a : op_a;
  assign b_mag = (div_sgn & op_b[XLEN-1]) ? -op_b : op_b;

  assign rem_sh      = {rem_q, quo_q[XLEN-1]};
  assign rem_sub     = rem_sh - {1'b0, dvs_q};
  assign quo_fix     = q_neg_q ? -quo_q : quo_q;
  assign rem_fix     = r_neg_q ? -rem_q : rem_q;
  assign div_fin_res = is_rem_q ? rem_fix : quo_fix;

  assign exe_res = !m_en4 ? alu_res : (is_div ? div_special_res : mul_res);

  // A divide is not started in the cycle right after reset, where stall must stay low.
  assign div_start = (state_q == IDLE) & valid4 & is_div & ~div_special & ~post_rst_q;
  assign stall     = ~rst & (div_start | (state_q == BUSY));

  always_comb begin
    valid5_d   = 1'b0;
    we5_d      = 1'b0;
    result5_d  = result5_q;
    rd5_d      = rd5_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    is_rem_d   = is_rem_q;
    rd_div_d   = rd_div_q;
    we_div_d   = we_div_q;
    post_rst_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid4) begin
          if (is_div && !div_special) begin
            if (div_start) begin
              state_d  = BUSY;
              cnt_d    = '0;
              quo_d    = a_mag;
              rem_d    = '0;
              dvs_d    = b_mag;
              q_neg_d  = div_sgn & (op_a[XLEN-1] ^ op_b[XLEN-1]);
              r_neg_d  = div_sgn & op_a[XLEN-1];
              is_rem_d = m_op4[1];
              rd_div_d = rd4;
              we_div_d = we4;
            end
          end else begin
            valid5_d  = 1'b1;
            we5_d     = we4;
            rd5_d     = rd4;
            result5_d = exe_res;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 5'd1;
        if (!rem_sub[XLEN]) begin
          rem_d = rem_sub[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        valid5_d  = 1'b1;
        we5_d     = we_div_q;
        rd5_d     = rd_div_q;
        result5_d = div_fin_res;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      is_rem_q   <= 1'b0;
      rd_div_q   <= '0;
      we_div_q   <= 1'b0;
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      is_rem_q   <= is_rem_d;
      rd_div_q   <= rd_div_d;
      we_div_q   <= we_div_d;
      post_rst_q <= post_rst_d;
    end
  end
`else
  logic unused_mdu;
  assign unused_mdu = ^{m_en4, m_op4};
  assign stall      = 1'b0;

  always_comb begin
    valid5_d  = valid4;
    we5_d     = valid4 & we4;
    result5_d = valid4 ? alu_res : result5_q;
    rd5_d     = valid4 ? rd4 : rd5_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid5_q  <= 1'b0;
      result5_q <= '0;
      rd5_q     <= '0;
      we5_q     <= 1'b0;
    end else begin
      valid5_q  <= valid5_d;
      result5_q <= result5_d;
      rd5_q     <= rd5_d;
      we5_q     <= we5_d;
    end
  end

  assign valid5  = valid5_q;
  assign result5 = result5_q;
  assign rd5     = rd5_q;
  assign we5     = we5_q;

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port valid4  input  1  an issue-stage instruction is present.
REQ-005 SHALL have port op_a, op_b  input  32 each  operands from issue stage; op_b is already immediate/shamt-muxed.
REQ-006 SHALL have port alu_fn4  input  4  ALU operation select.
REQ-007 SHALL have port m_en4  input  1  the instruction is an M-extension op.
REQ-008 SHALL have port m_op4  input  3  M op, RISC-V funct3 coding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 SHALL have ports rd4  input  5  and we4  input  1  destination address and write enable, passed through.
REQ-010 SHALL have port stall  output  1  upstream holds all *4 inputs and valid4 while high.
REQ-011 SHALL have ports valid5  output  1,  result5  output  32,  rd5  output  5,  we5  output  1  pipe #5 registers toward the memory stage.

Function
REQ-012 SHALL decode alu_fn4 as 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; codes 10-15 SHALL yield 0.
REQ-013 SHALL use only op_b[4:0] as the shift amount; all arithmetic is modulo 2^32.
REQ-014 SHALL complete ALU ops and MUL/MULH/MULHSU/MULHU in 1 cycle: inputs accepted in cycle T appear on the *5 outputs from cycle T+1.
REQ-015 SHALL return the low 32 product bits for MUL and the high 32 bits for MULH (s×s), MULHSU (s×u) and MULHU (u×u).
REQ-016 SHALL run DIV/DIVU/REM/REMU on an iterative restoring divider: FSM states IDLE, BUSY, DONE.
REQ-017 IDLE->BUSY SHALL occur when valid4 & m_en4 & m_op4>=4, no special case applies, and the FSM is in IDLE; stall SHALL be high in that cycle T.
REQ-018 BUSY SHALL last exactly 32 cycles (T+1..T+32) with a 5-bit counter, stall high, and valid5=0 written each cycle.
REQ-019 BUSY->DONE SHALL occur after the 32nd iteration; in DONE stall SHALL be low, the result SHALL be registered, and the FSM SHALL return to IDLE; valid5=1 SHALL appear at T+34.
REQ-020 Signed division SHALL divide magnitudes, negate the quotient if the operand signs differ, and give the remainder the dividend's sign.
REQ-021 Divide by zero SHALL complete in 1 cycle without BUSY: quotient 0xFFFFFFFF, remainder = op_a.
REQ-022 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL complete in 1 cycle: quotient 0x80000000, remainder 0.
REQ-023 When valid4=0 and the FSM is IDLE, the next cycle SHALL have valid5=0 and we5=0.
REQ-024 SHALL force we5=0 whenever valid5=0.
REQ-025 SHALL accept a new instruction in the cycle after DONE (back-to-back divides allowed).

Reset
REQ-026 On rst=1 at a clock edge, SHALL set FSM=IDLE, counter=0, valid5=0, result5=0, rd5=0, we5=0.
REQ-027 SHALL keep stall=0 while rst=1 and during the first cycle after it.
REQ-028 Reset during BUSY SHALL abandon the divide with no result emitted.

Configuration
REQ-029 With macro EXE_MDU_EN defined, the multiplier, the divider, the FSM and the stall logic SHALL be present as in REQ-014..REQ-025.
REQ-030 Without EXE_MDU_EN, SHALL ignore m_en4 and m_op4, execute every instruction per alu_fn4, tie stall to 0, and contain no FSM.

Verification
REQ-031 ADD op_a=0x7FFFFFFF, op_b=1 -> next cycle result5=0x80000000, valid5=1, rd5/we5 match inputs.
REQ-032 SRA op_a=0x80000000, op_b=0x24 -> result5=0xF8000000 (shift 4).
REQ-033 MULH op_a=op_b=0x80000000 -> result5=0x40000000 after 1 cycle.
REQ-034 DIV op_a=-7, op_b=2 at T -> stall high T..T+32, low T+33; result5=0xFFFFFFFD, valid5=1 at T+34; REM gives 0xFFFFFFFF.
REQ-035 DIVU op_b=0 -> 1-cycle result 0xFFFFFFFF, stall never high; REM 0x80000000/0xFFFFFFFF -> 0 in 1 cycle.
REQ-036 Assert rst at T+10 of a DIV -> FSM IDLE, stall 0, valid5 stays 0 with no late result; the next ADD completes in 1 cycle.
